prewish_blinky: RTL and testbench
=================================

// Module: prewish_blinky
// PURPOSE
//   Receives an 8-bit blink pattern on a one-cycle strobe and replays it on one active-high LED, MSB first.
//   Each bit is held for 2**SYSCLK_DIV_BITS clocks.
//   Sits downstream of prewish_mentor, which drives STB_I/DAT_I.
//   CLK_I and RST_I come from prewish_syscon.
// PARAMETERS
//   SYSCLK_DIV_BITS  21  width of the bit-period prescaler; bit period = 2**SYSCLK_DIV_BITS clocks (>=1)
// PORTS
//   CLK_I   in   1  single system clock; all logic on its rising edge
//   RST_I   in   1  reset, synchronous, active-low
//   STB_I   in   1  load strobe; a rising edge (0->1) loads DAT_I
//   DAT_I   in   8  blink pattern; bit 7 is played first
//   o_led   out  1  LED drive, active high, registered
// BEHAVIOUR
//   - One clock (CLK_I). Reset is synchronous and active-low: RST_I=0 sampled at a rising edge resets.
//   - Reset clears pattern, shift register, prescaler, bit index, stb_prev and o_led to 0. Reset wins over a simultaneous strobe.
//   - Before the first load after reset, o_led stays 0.
//   - Edge detect: stb_prev <= STB_I every cycle.
//     load = STB_I & ~stb_prev.
//     A strobe held high loads once only; DAT_I changes while STB_I stays high are ignored.
//     STB_I already high when reset releases counts as a rising edge and loads.
//   - Load cycle actions:
//     pattern <= DAT_I; shift <= DAT_I; prescaler <= 0; bit index <= 0; running <= 1.
//     o_led = DAT_I[7] from the next cycle (1-cycle latency).
//   - Playback:
//     o_led follows shift[7] (registered).
//     The prescaler increments each clock; tick = prescaler all-ones.
//     On tick: shift rotates left 1 and bit index increments (3-bit, wraps 7->0).
//     Every bit, including the first, lasts exactly 2**SYSCLK_DIV_BITS clocks; a full pattern lasts 8*2**SYSCLK_DIV_BITS clocks.
//   - End of pattern: on the tick where index wraps 7->0, shift reloads from pattern and playback repeats seamlessly (no gap).
//   - New strobe mid-playback: aborts the current pattern and restarts with the new data, as on a load.
//   - Reset mid-playback: o_led=0 from the next cycle; remains 0 until the next load.
//   - Pattern 8'h00 gives o_led constantly 0. Pattern 8'hFF gives o_led constantly 1.
// CONFIGURATION
//   PREWISH_BLINKY_ONESHOT_EN
//   - Undefined (default): the pattern loops forever, as above.
//   - Defined: at the tick ending bit 0 (index 7->0), running <= 0 and o_led <= 0.
//     LED stays 0 and the prescaler is held until the next load.
// TESTING (SYSCLK_DIV_BITS=3 -> 8 clocks/bit, 64 clocks/pattern)
//   1. Hold RST_I=0 10 clocks, release, no strobe -> o_led=0 for 200 clocks.
//   2. DAT_I=8'hA8, STB_I=1 for 1 clock -> o_led from next clock: 1,0,1,0,1,0,0,0 (8 clocks each);
//      the sequence repeats every 64 clocks.
//   3. During test 2 at ~300 clocks, strobe 1 clock with DAT_I=8'hCA -> o_led=1 next clock, then 1,1,0,0,1,0,1,0 per 8 clocks.
//      No leftover 8'hA8 bits appear.
//   4. STB_I held high 400 clocks with DAT_I=8'hCA, DAT_I->8'hFF after 100 clocks:
//      -> 8'hCA plays and loops throughout; no restart at STB_I fall.
//   5. RST_I=0 for 1 clock mid-bit -> o_led=0 next clock and stays 0; the next strobe restarts correctly.
//   6. With PREWISH_BLINKY_ONESHOT_EN, strobe 8'hA8 -> one pass of 64 clocks, then o_led=0 for 500 clocks.

Source files
------------

// File: rtl/prewish_blinky.sv
// Replays a strobed 8-bit pattern MSB-first on one LED, one bit per 2**SYSCLK_DIV_BITS clocks.
// Optional: define PREWISH_BLINKY_ONESHOT_EN to play the pattern once instead of looping.
module prewish_blinky #(
  parameter int unsigned SYSCLK_DIV_BITS = 21
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       STB_I,
  input  logic [7:0] DAT_I,
  output logic       o_led
);

  typedef enum logic {
    IDLE,
    PLAY
  } state_t;

  state_t                     state, state_next;
  logic [7:0]                 pattern, pattern_next;
  logic [7:0]                 shift, shift_next;
  logic [SYSCLK_DIV_BITS-1:0] prescaler, prescaler_next;
  logic [2:0]                 bit_idx, bit_idx_next;
  logic                       stb_prev;
  logic                       led_next;
  logic                       load;
  logic                       tick;

  assign load = STB_I & ~stb_prev;
  assign tick = &prescaler;

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state     <= IDLE;
      pattern   <= '0;
      shift     <= '0;
      prescaler <= '0;
      bit_idx   <= '0;
      stb_prev  <= 1'b0;
      o_led     <= 1'b0;
    end else begin
      state     <= state_next;
      pattern   <= pattern_next;
      shift     <= shift_next;
      prescaler <= prescaler_next;
      bit_idx   <= bit_idx_next;
      stb_prev  <= STB_I;
      o_led     <= led_next;
    end
  end

  // The LED is driven from the next shift MSB so the first bit lasts a full period.
  always_comb begin
    state_next     = state;
    pattern_next   = pattern;
    shift_next     = shift;
    prescaler_next = prescaler;
    bit_idx_next   = bit_idx;
    led_next       = 1'b0;
    if (load) begin
      pattern_next   = DAT_I;
      shift_next     = DAT_I;
      prescaler_next = '0;
      bit_idx_next   = '0;
      state_next     = PLAY;
      led_next       = DAT_I[7];
    end else if (state == PLAY) begin
      prescaler_next = prescaler + 1'b1;
      led_next       = shift[7];
      if (tick) begin
        bit_idx_next = bit_idx + 3'd1;
        if (bit_idx == 3'd7) begin
`ifdef PREWISH_BLINKY_ONESHOT_EN
          shift_next = pattern;
          state_next = IDLE;
          led_next   = 1'b0;
`else
          shift_next = pattern;
          led_next   = pattern[7];
`endif
        end else begin
          shift_next = {shift[6:0], shift[7]};
          led_next   = shift[6];
        end
      end
    end
  end

endmodule

// File: tb/tb_prewish_blinky.sv
// Randomized self-checking bench for prewish_blinky with 8 clocks per bit.
module tb_prewish_blinky;

  localparam int unsigned DIV = 3;
  localparam int BIT_CLKS = 8;

  logic       clk;
  logic       rst_n;
  logic       stb;
  logic [7:0] dat;
  logic       led;

  int checks = 0;
  int errors = 0;

  // Reference model state: pattern, clocks since the load edge, playing flag.
  logic       m_prev   = 1'b0;
  logic       m_active = 1'b0;
  logic [7:0] m_pat    = '0;
  int         m_age    = 0;

  prewish_blinky #(.SYSCLK_DIV_BITS(DIV)) dut (
    .CLK_I(clk),
    .RST_I(rst_n),
    .STB_I(stb),
    .DAT_I(dat),
    .o_led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_led();
    int idx;
    if (!m_active) return 1'b0;
`ifdef PREWISH_BLINKY_ONESHOT_EN
    if (m_age >= 8 * BIT_CLKS) return 1'b0;
`endif
    idx = 7 - ((m_age / BIT_CLKS) % 8);
    return m_pat[idx];
  endfunction

  // Advance one clock: drive inputs on the falling edge, update the model at the
  // rising edge, and leave the caller 1 time unit after that edge.
  task automatic cycle(input logic r, input logic s, input logic [7:0] d);
    @(negedge clk);
    rst_n = r;
    stb   = s;
    dat   = d;
    @(posedge clk);
    if (!r) begin
      m_active = 1'b0;
      m_prev   = 1'b0;
    end else begin
      if (s && !m_prev) begin
        m_pat    = d;
        m_age    = 0;
        m_active = 1'b1;
      end else if (m_active) begin
        m_age++;
      end
      m_prev = s;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 8'($urandom));
      checks++;
      if (led !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got %b exp 0", i, led);
      end
    end
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, 1'b0, 8'($urandom));
      checks++;
      if (led !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_strobe cyc %0d got %b exp 0", i, led);
      end
    end
  endtask

  task automatic test_pattern_a8();
    cycle(1'b1, 1'b1, 8'hA8);
    checks++;
    if (led !== 1'b1) begin
      errors++;
      $display("FAIL a8_first_bit got %b exp 1", led);
    end
    for (int i = 0; i < 140; i++) begin
      cycle(1'b1, 1'b0, 8'($urandom));
      checks++;
      if (led !== model_led()) begin
        errors++;
        $display("FAIL a8_play cyc %0d got %b exp %b", i, led, model_led());
      end
    end
  endtask

  task automatic test_restart();
    cycle(1'b1, 1'b1, 8'hA8);
    for (int i = 0; i < 299; i++) begin
      cycle(1'b1, 1'b0, 8'h00);
      checks++;
      if (led !== model_led()) begin
        errors++;
        $display("FAIL restart_pre cyc %0d got %b exp %b", i, led, model_led());
      end
    end
    cycle(1'b1, 1'b1, 8'hCA);
    checks++;
    if (led !== 1'b1) begin
      errors++;
      $display("FAIL restart_first_bit got %b exp 1", led);
    end
    for (int i = 0; i < 130; i++) begin
      cycle(1'b1, 1'b0, 8'h00);
      checks++;
      if (led !== model_led()) begin
        errors++;
        $display("FAIL restart_ca cyc %0d got %b exp %b", i, led, model_led());
      end
    end
  endtask

  task automatic test_held_strobe();
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 400; i++) begin
      cycle(1'b1, 1'b1, (i < 100) ? 8'hCA : 8'hFF);
      checks++;
      if (led !== model_led()) begin
        errors++;
        $display("FAIL held_strobe cyc %0d got %b exp %b", i, led, model_led());
      end
    end
    for (int i = 0; i < 70; i++) begin
      cycle(1'b1, 1'b0, 8'hFF);
      checks++;
      if (led !== model_led()) begin
        errors++;
        $display("FAIL held_release cyc %0d got %b exp %b", i, led, model_led());
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 50; i++) begin
      checks++;
      if (led !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid cyc %0d got %b exp 0", i, led);
      end
      cycle(1'b1, 1'b0, 8'h00);
    end
    cycle(1'b1, 1'b1, 8'($urandom));
    for (int i = 0; i < 80; i++) begin
      cycle(1'b1, 1'b0, 8'h00);
      checks++;
      if (led !== model_led()) begin
        errors++;
        $display("FAIL reset_reload cyc %0d got %b exp %b", i, led, model_led());
      end
    end
  endtask

  task automatic test_reset_vs_strobe();
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h80);
    checks++;
    if (led !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins got %b exp 0", led);
    end
    cycle(1'b1, 1'b1, 8'h80);
    checks++;
    if (led !== 1'b1) begin
      errors++;
      $display("FAIL stb_high_at_release got %b exp 1", led);
    end
    for (int i = 0; i < 70; i++) begin
      cycle(1'b1, 1'b1, 8'h00);
      checks++;
      if (led !== model_led()) begin
        errors++;
        $display("FAIL release_load cyc %0d got %b exp %b", i, led, model_led());
      end
    end
  endtask

  task automatic test_constant_patterns();
    logic [7:0] pats [2];
    pats[0] = 8'h00;
    pats[1] = 8'hFF;
    for (int p = 0; p < 2; p++) begin
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b1, 1'b1, pats[p]);
      for (int i = 0; i < 140; i++) begin
        checks++;
        if (led !== model_led()) begin
          errors++;
          $display("FAIL const_%02h cyc %0d got %b exp %b", pats[p], i, led, model_led());
        end
        cycle(1'b1, 1'b0, 8'($urandom));
      end
    end
  endtask

  task automatic test_random();
    logic r, s;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) != 0);
      s = ($urandom_range(0, 99) < 3) ? 1'b1 : (stb & ($urandom_range(0, 3) != 0));
      cycle(r, s, 8'($urandom));
      checks++;
      if (led !== model_led()) begin
        errors++;
        $display("FAIL random cyc %0d got %b exp %b", i, led, model_led());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    stb   = 1'b0;
    dat   = '0;
    test_reset();
    test_pattern_a8();
    test_restart();
    test_held_strobe();
    test_reset_mid();
    test_reset_vs_strobe();
    test_constant_patterns();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
